// File: rtl/right_shift_seq_pkg.sv
// Shared definitions for the shifter family: state encodings and default sizes.
// The left shifter uses the same defaults.
package right_shift_seq_pkg;

    localparam int SHIFT_W  = 4;
    localparam int SHIFT_KW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/right_shift_seq_shr1_stage.sv
// Combinational one-position right shift.
// The vacated MSB takes the sign bit when arith is set, otherwise zero.
module shr1_stage
    import right_shift_seq_pkg::*;
#(
    parameter int WIDTH = SHIFT_W
) (
    input  logic [WIDTH-1:0] d,
    input  logic             arith,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    assign q    = {arith & d[WIDTH-1], d[WIDTH-1:1]};
    assign sout = d[0];

endmodule

// File: rtl/right_shift_seq.sv
// Sequential right shifter: one bit position per clock behind a start/busy/done handshake.
// The operand is loaded into the result register and shifted in place.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; out/carry hold the previous result
//   ST_SHIFT | busy; one position shifted per cycle, cnt counts down to 1
//   ST_DONE  | one-cycle done pulse; a start here is accepted back-to-back
module right_shift_seq
    import right_shift_seq_pkg::*;
#(
    parameter int WIDTH = SHIFT_W,
    parameter int KW    = SHIFT_KW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [KW-1:0]    k,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    state_e           state_q;
    logic [KW-1:0]    cnt_q;
    logic             arith_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] shift_d;
    logic             sout_d;

    shr1_stage #(.WIDTH(WIDTH)) u_stage (
        .d     (out_q),
        .arith (arith_q),
        .q     (shift_d),
        .sout  (sout_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            arith_q <= 1'b0;
            out_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        out_q   <= in;
                        arith_q <= arith;
                        carry_q <= 1'b0;
                        cnt_q   <= k;
                        if (k == '0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // start is deliberately ignored here; no request queueing
                    out_q   <= shift_d;
                    carry_q <= sout_d;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == KW'(1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign out   = out_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_right_shift_seq.sv
// Self-checking bench for right_shift_seq: directed table, randomized ops against
// an arithmetic reference, and hand-written handshake corner sequences.
module tb_right_shift_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       arith = 1'b0;
    logic [3:0] din = 4'd0;
    logic [1:0] kin = 2'd0;
    logic       busy, done, carry;
    logic [3:0] dout;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    right_shift_seq #(.WIDTH(4), .KW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (din),
        .k     (kin),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .out   (dout),
        .carry (carry)
    );

    typedef struct {
        logic [3:0] a;
        logic [1:0] kk;
        logic       ar;
        logic [3:0] eo;
        logic       ec;
        int         el;
        int         eb;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain shift operators on the original operand.
    task automatic model(input logic [3:0] a, input logic [1:0] kk, input logic ar,
                         output logic [3:0] eo, output logic ec);
        logic signed [3:0] s;
        logic [3:0] tmp;
        s = a;
        tmp = a;
        if (ar) eo = s >>> kk;
        else    eo = a >> kk;
        if (kk == 2'd0) ec = 1'b0;
        else            ec = tmp[int'(kk) - 1];
    endtask

    // Issue one request and wait for done; lat counts cycles from the accepting edge.
    task automatic run_op(input logic [3:0] a, input logic [1:0] kk, input logic ar,
                          output logic [3:0] o, output logic c,
                          output int lat, output int bcnt, output bit to);
        @(negedge clk);
        din = a; kin = kk; arith = ar; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0; to = 1'b1; o = 4'd0; c = 1'b0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (done) begin
            to = 1'b0;
            o = dout;
            c = carry;
        end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] o, eo;
        logic c, ec;
        int lat, bcnt, w;
        bit to;

        tbl[0] = '{4'b1011, 2'd2, 1'b0, 4'b0010, 1'b1, 3, 2};
        tbl[1] = '{4'b1001, 2'd3, 1'b1, 4'b1111, 1'b0, 4, 3};
        tbl[2] = '{4'b0110, 2'd0, 1'b0, 4'b0110, 1'b0, 1, 0};
        tbl[3] = '{4'b1101, 2'd1, 1'b1, 4'b1110, 1'b1, 2, 1};
        tbl[4] = '{4'b0111, 2'd3, 1'b1, 4'b0000, 1'b1, 4, 3};
        tbl[5] = '{4'b1111, 2'd3, 1'b0, 4'b0001, 1'b1, 4, 3};

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", dout, 0);
        check("rst_carry", carry, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].kk, tbl[i].ar, o, c, lat, bcnt, to);
            check($sformatf("tbl%0d_timeout", i), to, 0);
            check($sformatf("tbl%0d_out", i), o, tbl[i].eo);
            check($sformatf("tbl%0d_carry", i), c, tbl[i].ec);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].el);
            check($sformatf("tbl%0d_busy_cycles", i), bcnt, tbl[i].eb);
            @(negedge clk);
            check($sformatf("tbl%0d_done_pulse", i), done, 0);
            check($sformatf("tbl%0d_out_held", i), dout, tbl[i].eo);
        end

        for (int i = 0; i < 40; i++) begin
            logic [3:0] a;
            logic [1:0] kk;
            logic ar;
            a  = 4'($urandom_range(0, 15));
            kk = 2'($urandom_range(0, 3));
            ar = 1'($urandom_range(0, 1));
            model(a, kk, ar, eo, ec);
            run_op(a, kk, ar, o, c, lat, bcnt, to);
            check($sformatf("rnd%0d_timeout", i), to, 0);
            check($sformatf("rnd%0d_out", i), o, eo);
            check($sformatf("rnd%0d_carry", i), c, ec);
            check($sformatf("rnd%0d_latency", i), lat, int'(kk) + 1);
            check($sformatf("rnd%0d_busy_cycles", i), bcnt, int'(kk));
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        din = 4'b1000; kin = 2'd3; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        din = 4'b1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("busy_start_done_seen", done, 1);
        check("busy_start_out", dout, 4'b0001);
        check("busy_start_carry", carry, 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("busy_start_not_queued", busy | done, 0);
        end

        // start held high across done: back-to-back acceptance
        @(negedge clk);
        din = 4'b1100; kin = 2'd1; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_busy_first", busy, 1);
        @(negedge clk);
        check("b2b_done_first", done, 1);
        check("b2b_out_first", dout, 4'b0110);
        @(negedge clk);
        check("b2b_no_idle_gap_busy", busy, 1);
        check("b2b_no_idle_gap_done", done, 0);
        start = 1'b0;
        @(negedge clk);
        check("b2b_done_second", done, 1);
        check("b2b_out_second", dout, 4'b0110);
        @(negedge clk);
        check("b2b_idle_after", busy | done, 0);

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        din = 4'b1011; kin = 2'd3; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_pre_out", dout, 4'b0101);
        check("mid_pre_carry", carry, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_out", dout, 0);
        check("mid_rst_carry", carry, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy | done, 0);
        run_op(4'b1110, 2'd2, 1'b0, o, c, lat, bcnt, to);
        check("post_rst_timeout", to, 0);
        check("post_rst_out", o, 4'b0011);
        check("post_rst_carry", c, 1);
        check("post_rst_latency", lat, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
